// File: rtl/distance_pkg.sv
// Shared constants and width helpers for the multi-channel sonar distance history.
package distance_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_DEPTH  = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Running sum of DEPTH samples never needs more than this many bits.
   function automatic int sum_width(input int data_w, input int depth);
      return data_w + clog2(depth);
   endfunction

endpackage

// File: rtl/distance_channel.sv
// One sonar channel: strobe edge detect, sample history shift register,
// running sum for the moving average, and fill tracking.
module distance_channel
   import distance_pkg::*;
#(
   parameter  int DATA_W = DEFAULT_DATA_W,
   parameter  int DEPTH  = DEFAULT_DEPTH,
   localparam int IDX_W  = clog2(DEPTH),
   localparam int SUM_W  = sum_width(DATA_W, DEPTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             distance,
   input  logic                          new_dist,
   input  logic                          clear_ch,
   output logic                          sample_strobe,
   output logic                          data_valid,
   output logic                          avg_valid,
   output logic [DATA_W-1:0]             avg_out,
   output logic [IDX_W:0]                fill_count,
   output logic [DEPTH-1:0][DATA_W-1:0]  hist
);

   localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

   logic                         prev_q;
   logic [DEPTH-1:0][DATA_W-1:0] hist_q;
   logic [SUM_W-1:0]             sum_q;
   logic [IDX_W:0]               fill_q;
   logic                         strobe_q;

   logic                         capture;
   logic                         full;
   logic [DATA_W-1:0]            drop;
   logic [SUM_W-1:0]             sum_next;

   assign capture  = new_dist & ~prev_q;
   assign full     = (fill_q == FULL_CNT);
   // Once the history is full the oldest entry falls off the end and leaves the sum.
   assign drop     = full ? hist_q[DEPTH-1] : '0;
   assign sum_next = sum_q + SUM_W'(distance) - SUM_W'(drop);

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q   <= 1'b1;
         hist_q   <= '0;
         sum_q    <= '0;
         fill_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         prev_q   <= new_dist;
         strobe_q <= 1'b0;
         if (clear_ch) begin
            hist_q <= '0;
            sum_q  <= '0;
            fill_q <= '0;
         end else if (capture) begin
            hist_q   <= {hist_q[DEPTH-2:0], distance};
            sum_q    <= sum_next;
            strobe_q <= 1'b1;
            if (!full) fill_q <= fill_q + 1'b1;
         end
      end
   end

   assign sample_strobe = strobe_q;
   assign data_valid    = (fill_q != '0);
   assign avg_valid     = full;
   assign avg_out       = full ? sum_q[IDX_W +: DATA_W] : hist_q[0];
   assign fill_count    = fill_q;
   assign hist          = hist_q;

endmodule

// File: rtl/distance_history.sv
// Multi-channel distance history: per-channel capture/average plus a registered
// random-access read port over all channel histories.
module distance_history
   import distance_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = DEFAULT_DATA_W,
   parameter  int DEPTH  = DEFAULT_DEPTH,
   localparam int IDX_W  = clog2(DEPTH),
   localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH*DATA_W-1:0]     distance,
   input  logic [NUM_CH-1:0]            new_dist,
   input  logic [NUM_CH-1:0]            clear_ch,
   output logic [NUM_CH-1:0]            sample_strobe,
   output logic [NUM_CH-1:0]            data_valid,
   output logic [NUM_CH-1:0]            avg_valid,
   output logic [NUM_CH*DATA_W-1:0]     avg_out,
   output logic [NUM_CH*(IDX_W+1)-1:0]  fill_count,
   input  logic [CH_W-1:0]              rd_ch,
   input  logic [IDX_W-1:0]             rd_idx,
   output logic [DATA_W-1:0]            rd_data
);

   logic [DEPTH-1:0][DATA_W-1:0] hist_bus [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      distance_channel #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_channel (
         .clk           (clk),
         .reset         (reset),
         .distance      (distance[c*DATA_W +: DATA_W]),
         .new_dist      (new_dist[c]),
         .clear_ch      (clear_ch[c]),
         .sample_strobe (sample_strobe[c]),
         .data_valid    (data_valid[c]),
         .avg_valid     (avg_valid[c]),
         .avg_out       (avg_out[c*DATA_W +: DATA_W]),
         .fill_count    (fill_count[c*(IDX_W+1) +: (IDX_W+1)]),
         .hist          (hist_bus[c])
      );
   end

   // Unmatched channel selects (rd_ch >= NUM_CH) fall through to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (int'(rd_ch) == c) rd_data <= hist_bus[c][rd_idx];
         end
      end
   end

endmodule

// File: tb/tb_distance_history.sv
// Directed bench for distance_history with two channels of four 8-bit entries.
module tb_distance_history;

   localparam int NUM_CH = 2;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int IDX_W  = 2;
   localparam int FC_W   = IDX_W + 1;

   logic                        clk = 1'b0;
   logic                        reset;
   logic [NUM_CH*DATA_W-1:0]    distance;
   logic [NUM_CH-1:0]           new_dist;
   logic [NUM_CH-1:0]           clear_ch;
   logic [NUM_CH-1:0]           sample_strobe;
   logic [NUM_CH-1:0]           data_valid;
   logic [NUM_CH-1:0]           avg_valid;
   logic [NUM_CH*DATA_W-1:0]    avg_out;
   logic [NUM_CH*FC_W-1:0]      fill_count;
   logic [0:0]                  rd_ch;
   logic [IDX_W-1:0]            rd_idx;
   logic [DATA_W-1:0]           rd_data;

   int errors = 0;
   int checks = 0;

   distance_history #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .distance      (distance),
      .new_dist      (new_dist),
      .clear_ch      (clear_ch),
      .sample_strobe (sample_strobe),
      .data_valid    (data_valid),
      .avg_valid     (avg_valid),
      .avg_out       (avg_out),
      .fill_count    (fill_count),
      .rd_ch         (rd_ch),
      .rd_idx        (rd_idx),
      .rd_data       (rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cap(input int ch, input logic [7:0] val);
      distance[ch*DATA_W +: DATA_W] = val;
      new_dist[ch] = 1'b1;
      tick();
      new_dist[ch] = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] fc(input int ch);
      return 32'(fill_count[ch*FC_W +: FC_W]);
   endfunction

   function automatic logic [31:0] av(input int ch);
      return 32'(avg_out[ch*DATA_W +: DATA_W]);
   endfunction

   initial begin
      reset = 1'b1; distance = '0; new_dist = '0; clear_ch = '0; rd_ch = '0; rd_idx = '0;
      tick(); tick();
      chk("rst_strobe", 32'(sample_strobe), 32'h0);
      chk("rst_valid",  32'(data_valid),    32'h0);
      chk("rst_fill",   32'(fill_count),    32'h0);
      chk("rst_rd",     32'(rd_data),       32'h0);
      reset = 1'b0;
      tick();

      // Fill ch0 and roll one sample through the full history
      cap(0, 8'h10); cap(0, 8'h20); cap(0, 8'h30);
      chk("t1_fill3",   fc(0), 32'd3);
      chk("t1_nofull",  32'(avg_valid[0]), 32'd0);
      chk("t1_avg_nf",  av(0), 32'h30);
      cap(0, 8'h40);
      chk("t1_full",    32'(avg_valid[0]), 32'd1);
      chk("t1_avg4",    av(0), 32'h28);
      cap(0, 8'h50);
      chk("t1_avg5",    av(0), 32'h38);
      chk("t1_fillsat", fc(0), 32'd4);

      // Random-access reads
      rd_ch = 1'b0;
      rd_idx = 2'd0; tick(); chk("t5_rd0", 32'(rd_data), 32'h50);
      rd_idx = 2'd1; tick(); chk("t5_rd1", 32'(rd_data), 32'h40);
      rd_idx = 2'd2; tick(); chk("t5_rd2", 32'(rd_data), 32'h30);
      rd_idx = 2'd3; tick(); chk("t5_rd3", 32'(rd_data), 32'h20);
      rd_ch = 1'b1; rd_idx = 2'd0; tick(); chk("t5_rd_empty", 32'(rd_data), 32'h00);
      rd_ch = 1'b0;
      distance[7:0] = 8'h60; new_dist[0] = 1'b1;
      tick();
      chk("t5_rd_precap", 32'(rd_data), 32'h50);
      chk("t5_strobe",    32'(sample_strobe), 32'h1);
      new_dist[0] = 1'b0;
      tick();
      chk("t5_rd_post",   32'(rd_data), 32'h60);
      chk("t5_avg",       av(0), 32'h48);

      // Held strobe with data changing mid-pulse
      distance[7:0] = 8'h88; new_dist[0] = 1'b1;
      tick();
      chk("t2_strobe_on", 32'(sample_strobe), 32'h1);
      distance[7:0] = 8'h99;
      tick(); chk("t2_strobe_off1", 32'(sample_strobe), 32'h0);
      tick(); chk("t2_strobe_off2", 32'(sample_strobe), 32'h0);
      tick(); tick();
      chk("t2_strobe_off4", 32'(sample_strobe), 32'h0);
      new_dist[0] = 1'b0;
      tick();
      chk("t2_rd_newest", 32'(rd_data), 32'h88);
      chk("t2_avg",       av(0), 32'h5E);
      chk("t2_ch1_empty", 32'(data_valid[1]), 32'd0);

      // Strobe already high at reset release is ignored
      new_dist[0] = 1'b1; reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      chk("t3_no_cap",   fc(0), 32'd0);
      chk("t3_no_valid", 32'(data_valid), 32'h0);
      new_dist[0] = 1'b0;
      tick();
      distance[7:0] = 8'hCC; new_dist[0] = 1'b1;
      tick();
      chk("t3_strobe", 32'(sample_strobe), 32'h1);
      new_dist[0] = 1'b0; rd_idx = 2'd1;
      tick();
      chk("t3_fill1",  fc(0), 32'd1);
      chk("t3_avg",    av(0), 32'hCC);
      chk("t3_nofull", 32'(avg_valid[0]), 32'd0);
      chk("t3_rd_old", 32'(rd_data), 32'h00);
      rd_idx = 2'd0;
      tick();
      chk("t3_rd_new", 32'(rd_data), 32'hCC);

      // Saturated samples and clear racing a capture
      cap(1, 8'hFF); cap(1, 8'hFF); cap(1, 8'hFF); cap(1, 8'hFF);
      chk("t4_avg_ff",  av(1), 32'hFF);
      chk("t4_full",    32'(avg_valid[1]), 32'd1);
      distance[15:8] = 8'h11; new_dist[1] = 1'b1; clear_ch[1] = 1'b1;
      tick();
      chk("t4_clr_strobe", 32'(sample_strobe), 32'h0);
      clear_ch[1] = 1'b0; new_dist[1] = 1'b0;
      tick();
      chk("t4_clr_fill",  fc(1), 32'd0);
      chk("t4_clr_valid", 32'(data_valid[1]), 32'd0);
      chk("t4_clr_avg",   av(1), 32'h00);
      chk("t4_ch0_fill",  fc(0), 32'd1);
      chk("t4_ch0_avg",   av(0), 32'hCC);

      // Simultaneous captures, then reset on a capture edge
      distance = 16'h0B0A; new_dist = 2'b11;
      tick();
      chk("t6_both_strobe", 32'(sample_strobe), 32'h3);
      new_dist = 2'b00;
      tick();
      chk("t6_fill0", fc(0), 32'd2);
      chk("t6_fill1", fc(1), 32'd1);
      chk("t6_avg0",  av(0), 32'h0A);
      chk("t6_avg1",  av(1), 32'h0B);
      distance = 16'h7777; new_dist = 2'b11; reset = 1'b1;
      tick();
      chk("t6_rst_strobe", 32'(sample_strobe), 32'h0);
      chk("t6_rst_valid",  32'(data_valid),    32'h0);
      chk("t6_rst_full",   32'(avg_valid),     32'h0);
      chk("t6_rst_fill",   32'(fill_count),    32'h0);
      chk("t6_rst_avg",    32'(avg_out),       32'h0);
      chk("t6_rst_rd",     32'(rd_data),       32'h0);
      reset = 1'b0; new_dist = 2'b00;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
